// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned LANE_MSB      = 3;
  localparam int unsigned ADDR_STEP_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Lane index counter and big-endian word assembly register.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                clear,
  input  logic                load,
  input  logic [BYTE_W-1:0]   byte_in,
  output logic [WORD_W-1:0]   word,
  output logic [IDX_W-1:0]    idx,
  output logic                full
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4:0]        lane_lsb;

  // Lane 3-idx holds the byte; for a 2-bit idx, 3-idx is simply ~idx.
  always_comb begin
    lane_lsb = {~idx_q, 3'b000};
    word_d   = word_q;
    idx_d    = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = word_q | (WORD_W'(byte_in) << lane_lsb);
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  // Assembly register; cleared lanes guarantee zero padding of short words.
  always_ff @(posedge clk) begin
    if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word = word_q;
  assign idx  = idx_q;
  assign full = (idx_q == IDX_W'(LANE_MSB));

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into big-endian words and writes them to instruction memory
// while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] word_cnt,
  output logic              err_partial,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((2 ** ADDR_W) - ADDR_STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              short_q, short_d;
  logic [ADDR_W-2:0] word_cnt_q, word_cnt_d;
  logic              err_partial_q, err_partial_d;
  logic              err_overflow_q, err_overflow_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addra_q, mem_addra_d;
  logic [WORD_W-1:0] mem_dina_q, mem_dina_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs_c;
  logic              pk_clear_c;
  logic [WORD_W-1:0] pk_word;
  logic [IDX_W-1:0]  pk_idx;
  logic              pk_full;
  logic [WORD_W-1:0] merged_c;
  logic [4:0]        lane_lsb_c;

  byte_packer u_packer (
    .clk     (clk),
    .clr     (clr),
    .clear   (pk_clear_c),
    .load    (hs_c),
    .byte_in (in_data),
    .word    (pk_word),
    .idx     (pk_idx),
    .full    (pk_full)
  );

  // Word as it will look once the byte on the bus lands in its lane.
  always_comb begin
    lane_lsb_c = {~pk_idx, 3'b000};
    merged_c   = pk_word | (WORD_W'(in_data) << lane_lsb_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    last_d         = last_q;
    short_d        = short_q;
    word_cnt_d     = word_cnt_q;
    err_partial_d  = err_partial_q;
    err_overflow_d = err_overflow_q;
    mem_addra_d    = mem_addra_q;
    mem_dina_d     = mem_dina_q;
    pk_clear_c     = 1'b0;
    hs_c           = in_valid & in_ready_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_COLLECT;
          addr_d         = base_addr;
          word_cnt_d     = '0;
          err_partial_d  = 1'b0;
          err_overflow_d = 1'b0;
          last_d         = 1'b0;
          short_d        = 1'b0;
          pk_clear_c     = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (hs_c && (pk_full || in_last)) begin
          state_d     = ST_WRITE;
          last_d      = in_last;
          short_d     = in_last & ~pk_full;
          mem_addra_d = addr_q;
          mem_dina_d  = merged_c;
        end
      end
      ST_WRITE: begin
        pk_clear_c = 1'b1;
        word_cnt_d = word_cnt_q + (ADDR_W-1)'(1);
        if (short_q) err_partial_d = 1'b1;
        if (last_q) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_LAST) begin
          err_overflow_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_COLLECT);
    we_d       = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      last_q         <= 1'b0;
      short_q        <= 1'b0;
      word_cnt_q     <= '0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      in_ready_q     <= 1'b0;
      we_q           <= 1'b0;
      mem_addra_q    <= '0;
      mem_dina_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      last_q         <= last_d;
      short_q        <= short_d;
      word_cnt_q     <= word_cnt_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
      in_ready_q     <= in_ready_d;
      we_q           <= we_d;
      mem_addra_q    <= mem_addra_d;
      mem_dina_q     <= mem_dina_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_ena      = we_q;
  assign mem_wea      = we_q;
  assign mem_addra    = mem_addra_q;
  assign mem_dina     = mem_dina_q;
  assign cpu_hold     = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_cnt     = word_cnt_q;
  assign err_partial  = err_partial_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and status values are queued
// by the stimulus and checked by a negedge monitor.
module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          clr, start, in_valid, in_last;
  logic [AW-1:0] base_addr;
  logic [7:0]    in_data;
  logic          in_ready, mem_ena, mem_wea, cpu_hold, busy, done;
  logic          err_partial, err_overflow;
  logic [AW-1:0] mem_addra;
  logic [31:0]   mem_dina;
  logic [AW-2:0] word_cnt;

  imem_loader #(.ADDR_W(AW), .ADDR_STEP(4)) dut (
    .clk(clk), .clr(clr), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_cnt(word_cnt),
    .err_partial(err_partial), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [7:0] sel; logic [31:0] e; } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic string sel_name(input logic [7:0] s);
    case (s)
      8'd0:  return "in_ready";
      8'd1:  return "mem_wea";
      8'd2:  return "cpu_hold";
      8'd3:  return "busy";
      8'd4:  return "done";
      8'd5:  return "word_cnt";
      8'd6:  return "err_partial";
      8'd7:  return "err_overflow";
      8'd8:  return "mem_addra";
      8'd9:  return "mem_dina";
      8'd10: return "writes_pending";
      default: return "handshake_timeout";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [7:0] s);
    case (s)
      8'd0:  return 32'(in_ready);
      8'd1:  return 32'(mem_wea);
      8'd2:  return 32'(cpu_hold);
      8'd3:  return 32'(busy);
      8'd4:  return 32'(done);
      8'd5:  return 32'(word_cnt);
      8'd6:  return 32'(err_partial);
      8'd7:  return 32'(err_overflow);
      8'd8:  return 32'(mem_addra);
      8'd9:  return mem_dina;
      8'd10: return 32'(wq.size());
      default: return 32'd1;
    endcase
  endfunction

  // Monitor: every write strobe must match the next queued write; queued status checks follow.
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (mem_wea === 1'b1) begin
      n_vec++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addra=%h dina=%h, required no write", mem_addra, mem_dina);
      end else begin
        w = wq.pop_front();
        if (mem_addra !== w.a || mem_dina !== w.d || mem_ena !== 1'b1) begin
          n_err++;
          $display("FAIL write: addra=%h dina=%h ena=%b, required addra=%h dina=%h ena=1",
                   mem_addra, mem_dina, mem_ena, w.a, w.d);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      n_vec++;
      if (actual(s.sel) !== s.e) begin
        n_err++;
        $display("FAIL %s: got %h, required %h", sel_name(s.sel), actual(s.sel), s.e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [7:0] sel, input logic [31:0] e);
    sq.push_back('{sel: sel, e: e});
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wq.push_back('{a: a, d: d});
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk(8'd255, 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    base_addr = a;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [7:0] prog1 [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};

  initial begin
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    base_addr = '0; in_data = '0;
    tick(); tick();
    clr = 1'b0;
    // Reset values
    for (int s = 0; s < 10; s++) chk(8'(s), 32'd0);
    tick();

    // Two full words from base 0, with done/cpu_hold timing
    exp_wr(10'h000, 32'h8C010004);
    exp_wr(10'h004, 32'h20020005);
    do_start(10'h000);
    chk(8'd0, 1); chk(8'd2, 1); chk(8'd3, 1);
    for (int i = 0; i < 8; i++) send(prog1[i], i == 7);
    chk(8'd1, 1); chk(8'd2, 1); chk(8'd4, 0);
    tick();
    chk(8'd4, 1); chk(8'd2, 0); chk(8'd3, 0); chk(8'd0, 0);
    chk(8'd5, 2); chk(8'd6, 0); chk(8'd7, 0); chk(8'd10, 0);
    tick();

    // Short final word is zero-padded
    exp_wr(10'h010, 32'hAABB0000);
    do_start(10'h010);
    chk(8'd4, 0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    tick();
    chk(8'd6, 1); chk(8'd4, 1); chk(8'd5, 1); chk(8'd10, 0);
    tick();

    // Address space exhausted at the top of memory
    exp_wr(10'h3F8, 32'h01020304);
    exp_wr(10'h3FC, 32'h05060708);
    do_start(10'h3F8);
    chk(8'd6, 0);
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0);
    for (int i = 8; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
      chk(8'd0, 0);
    end
    in_valid = 1'b0;
    chk(8'd7, 1); chk(8'd4, 1); chk(8'd5, 2); chk(8'd10, 0);
    tick();

    // Throttled input: one idle cycle between bytes
    exp_wr(10'h000, 32'h8C010004);
    exp_wr(10'h004, 32'h20020005);
    do_start(10'h000);
    chk(8'd7, 0);
    for (int i = 0; i < 8; i++) begin
      send(prog1[i], i == 7);
      tick();
    end
    chk(8'd4, 1); chk(8'd5, 2); chk(8'd10, 0);
    tick();

    // Clear after byte 6: first word written, nothing at address 4
    exp_wr(10'h000, 32'h8C010004);
    do_start(10'h000);
    for (int i = 0; i < 6; i++) send(prog1[i], 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk(8'd1, 0); chk(8'd3, 0); chk(8'd4, 0); chk(8'd2, 0); chk(8'd0, 0);
    tick(); tick(); tick();
    chk(8'd10, 0);
    tick();

    // Start during COLLECT is ignored
    exp_wr(10'h100, 32'h11223344);
    do_start(10'h100);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    do_start(10'h200);
    chk(8'd3, 1);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    tick();
    chk(8'd4, 1); chk(8'd5, 1); chk(8'd8, 32'h100); chk(8'd6, 0); chk(8'd10, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
